// File: rtl/hw2_seq_div.sv
// hw2_seq_div: sequential restoring divider, the inverse of the hw2
// add/sub-multiply datapath d = (a+/-b)*c. Recovers (a+/-b) from the
// product d and multiplier c, one quotient bit per clock, MSB first.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready request handshake; d, c, s captured on accept
//   d                 2*DATA_W-bit dividend (product)
//   c                 DATA_W-bit unsigned divisor
//   s                 1 = unsigned dividend, 0 = two's-complement dividend
//   out_valid/out_ready result handshake; results held until taken
//   q, r              quotient / remainder (signed when s=0, r follows d)
//   exact             remainder is zero
//   div0              divisor was zero (q all ones, r = d)
module hw2_seq_div #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   d,
  input  logic [DATA_W-1:0]     c,
  input  logic                  s,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   q,
  output logic [2*DATA_W-1:0]   r,
  output logic                  exact,
  output logic                  div0
);

  localparam int DW    = 2 * DATA_W;
  localparam int CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  // Holds the dividend magnitude; quotient bits shift in at the LSB, so
  // after DW steps it holds the unsigned quotient.
  logic [DW-1:0]       dvd_q;
  logic [DATA_W:0]     rem_q;
  logic [DATA_W-1:0]   dsr_q;
  logic                neg_q;
  logic                dz_q;
  logic [DW-1:0]       q_q;
  logic [DW-1:0]       r_q;
  logic                exact_q;
  logic                div0_q;
  logic                vld_q;

  logic [DATA_W:0]     rem_d;
  logic [DW-1:0]       dvd_d;

  function automatic logic signed [DW-1:0] twos_neg(input logic signed [DW-1:0] x);
    return -x;
  endfunction

  // Magnitude of the dividend; 16'h8000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [DW-1:0] dividend_mag(input logic [DW-1:0] x, input logic is_unsigned);
    if (!is_unsigned && x[DW-1])
      return twos_neg(x);
    return x;
  endfunction

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    logic [DATA_W:0] rem_sh;
    logic            qbit;
    rem_sh = {rem_q[DATA_W-1:0], dvd_q[DW-1]};
    qbit   = 1'b0;
    rem_d  = rem_sh;
    if (rem_sh >= {1'b0, dsr_q}) begin
      rem_d = rem_sh - {1'b0, dsr_q};
      qbit  = 1'b1;
    end
    dvd_d = {dvd_q[DW-2:0], qbit};
  end

  // Reset is folded in so a request can never be accepted during reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = vld_q;
  assign q         = q_q;
  assign r         = r_q;
  assign exact     = exact_q;
  assign div0      = div0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      exact_q <= 1'b0;
      div0_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        // Accept: capture operands
        IDLE: begin
          if (in_valid) begin
            dsr_q <= c;
            cnt_q <= '0;
            rem_q <= '0;
            if (c == '0) begin
              // Divide-by-zero still passes through FIX so its latency
              // is one cycle, like the normal result path's final step.
              dz_q    <= 1'b1;
              neg_q   <= 1'b0;
              dvd_q   <= d;
              state_q <= FIX;
            end else begin
              dz_q    <= 1'b0;
              neg_q   <= ~s & d[DW-1];
              dvd_q   <= dividend_mag(d, s);
              state_q <= CALC;
            end
          end
        end
        // Iterate: one quotient bit per cycle
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST)
            state_q <= FIX;
        end
        // Sign fix-up and result registration
        FIX: begin
          if (dz_q) begin
            q_q     <= '1;
            r_q     <= dvd_q;
            exact_q <= 1'b0;
            div0_q  <= 1'b1;
          end else begin
            if (neg_q) begin
              q_q <= twos_neg(dvd_q);
              r_q <= twos_neg({{(DW-DATA_W-1){1'b0}}, rem_q});
            end else begin
              q_q <= dvd_q;
              r_q <= {{(DW-DATA_W-1){1'b0}}, rem_q};
            end
            exact_q <= (rem_q == '0);
            div0_q  <= 1'b0;
          end
          vld_q   <= 1'b1;
          state_q <= DONE;
        end
        // Hold result until the consumer takes it
        DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hw2_seq_div.sv
module tb_hw2_seq_div;
  localparam int W  = 8;
  localparam int DW = 2 * W;
  localparam int NV = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d;
  logic [W-1:0]  c;
  logic          s;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] q;
  logic [DW-1:0] r;
  logic          exact;
  logic          div0;

  always #5 clk = ~clk;

  hw2_seq_div dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .c(c), .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .exact(exact), .div0(div0)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [W-1:0]  c;
    logic          s;
    logic [DW-1:0] eq;
    logic [DW-1:0] er;
    logic          ex;
    logic          dz;
  } vec_t;

  typedef struct {
    logic [DW-1:0] eq;
    logic [DW-1:0] er;
    logic          ex;
    logic          dz;
    int            lat;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] eq, input logic [DW-1:0] er,
                          input logic ex, input logic dz, input logic [W-1:0] cc);
    exp_t e;
    e.eq  = eq;
    e.er  = er;
    e.ex  = ex;
    e.dz  = dz;
    e.lat = (cc == '0) ? 1 : 2 * W + 1;
    sb.push_back(e);
  endtask

  // Drive one request; returns at the negedge just after the accept edge.
  task automatic send(input logic [DW-1:0] dd, input logic [W-1:0] cc, input logic ss);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    d = dd;
    c = cc;
    s = ss;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded), returning the latency in cycles.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s_valid", tag), out_valid, 1);
  endtask

  task automatic compare_result(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      chk($sformatf("%s_sb_empty", tag), 0, 1);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("%s_lat", tag), lat, e.lat);
    chk($sformatf("%s_q", tag), q, e.eq);
    chk($sformatf("%s_r", tag), r, e.er);
    chk($sformatf("%s_exact", tag), exact, e.ex);
    chk($sformatf("%s_div0", tag), div0, e.dz);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s_drop", tag), out_valid, 0);
    chk($sformatf("%s_rdy", tag), in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hi;

    //           d          c       s     q          r          exact div0
    vecs[0]  = '{16'd180,   8'd9,   1'b1, 16'd20,    16'd0,     1'b1, 1'b0};
    vecs[1]  = '{16'hFFBA,  8'd10,  1'b0, 16'hFFF9,  16'd0,     1'b1, 1'b0};
    vecs[2]  = '{16'd100,   8'd7,   1'b1, 16'd14,    16'd2,     1'b0, 1'b0};
    vecs[3]  = '{16'hFF9C,  8'd7,   1'b0, 16'hFFF2,  16'hFFFE,  1'b0, 1'b0};
    vecs[4]  = '{16'h1234,  8'd0,   1'b1, 16'hFFFF,  16'h1234,  1'b0, 1'b1};
    vecs[5]  = '{16'hFFFF,  8'd1,   1'b1, 16'hFFFF,  16'd0,     1'b1, 1'b0};
    vecs[6]  = '{16'h8000,  8'd1,   1'b0, 16'h8000,  16'd0,     1'b1, 1'b0};
    vecs[7]  = '{16'h8000,  8'd0,   1'b0, 16'hFFFF,  16'h8000,  1'b0, 1'b1};
    vecs[8]  = '{16'd100,   8'd7,   1'b0, 16'd14,    16'd2,     1'b0, 1'b0};
    vecs[9]  = '{16'hFFFF,  8'd2,   1'b0, 16'd0,     16'hFFFF,  1'b0, 1'b0};
    vecs[10] = '{16'hFFFF,  8'd255, 1'b1, 16'd257,   16'd0,     1'b1, 1'b0};
    vecs[11] = '{16'd0,     8'd5,   1'b1, 16'd0,     16'd0,     1'b1, 1'b0};
    vecs[12] = '{16'h8000,  8'd255, 1'b0, 16'hFF80,  16'hFF80,  1'b0, 1'b0};
    vecs[13] = '{16'h1234,  8'h10,  1'b1, 16'h0123,  16'd4,     1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    d = '0;
    c = '0;
    s = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_exact", exact, 0);
    chk("rst_div0", div0, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      push_exp(vecs[i].eq, vecs[i].er, vecs[i].ex, vecs[i].dz, vecs[i].c);
      send(vecs[i].d, vecs[i].c, vecs[i].s);
      wait_valid(tag, lat);
      compare_result(tag, lat);
      take_result(tag);
    end

    // Backpressure: result must hold while out_ready is low
    push_exp(16'd257, 16'd0, 1'b1, 1'b0, 8'd255);
    send(16'hFFFF, 8'd255, 1'b1);
    wait_valid("bp", lat);
    compare_result("bp", lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_q", k), q, 16'd257);
      chk($sformatf("bp_hold%0d_r", k), r, 16'd0);
      chk($sformatf("bp_hold%0d_vld", k), out_valid, 1);
      chk($sformatf("bp_hold%0d_inrdy", k), in_ready, 0);
    end
    take_result("bp");

    // Reset in the middle of a calculation (at iteration count 8)
    send(16'd500, 8'd3, 1'b1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready_during_rst", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_in_ready", in_ready, 1);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) hi++;
    end
    chk("abort_no_result", hi, 0);

    push_exp(16'd7, 16'd0, 1'b1, 1'b0, 8'd3);
    send(16'd21, 8'd3, 1'b1);
    wait_valid("post_abort", lat);
    compare_result("post_abort", lat);
    take_result("post_abort");

    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
